neutron_burst_scheduler: RTL
============================

# neutron_burst_scheduler

Sequences a configurable burst of neutron pulse windows by driving the pulse generator's reset, per-window delay and width, and an output gate. Each window can shift the pulse delay by a fixed step, so a single START produces a delay scan. The block sits between the host/config logic and the pulse generator, and reports progress through BUSY, DONE and ERR.

## Interface
- WINDOW, 512: ticks per window; must equal the generator window length.
- CLK  in  1  15 MHz system clock.
- RESET_N  in  1  synchronous, active-low reset.
- CFG_WE  in  1  latches CFG_* into shadow registers; honoured only in IDLE; clears ERR.
- CFG_DELAY  in  16  initial pulse delay in ticks.
- CFG_WIDTH  in  16  pulse width in ticks.
- CFG_STEP  in  16  delay increment applied after each window.
- CFG_NWIN  in  8  number of windows; 0 means an empty run.
- CFG_GAP  in  16  idle ticks between windows.
- START  in  1  begins a run; sampled only in IDLE.
- ABORT  in  1  terminates a run; ignored in IDLE.
- GEN_RESET  out  1  active-high reset to the generator.
- GEN_DELAY  out  16  delay for the current window.
- GEN_WIDTH  out  16  width for the current window.
- WIN_START  out  1  one-cycle strobe on the first RUN cycle of each window.
- PULSE_GATE  out  1  high only in RUN.
- WIN_IDX  out  8  index of the current window, starting at 0.
- BUSY  out  1  high in ARM, RUN and GAP.
- DONE  out  1  one-cycle pulse in FINISH.
- ERR  out  1  sticky; set when START is rejected.

## Operation
- States: IDLE, ARM, RUN, GAP, FINISH. All outputs are registered.
- Reset (RESET_N=0 at a CLK edge):
  - State goes to IDLE; GEN_RESET=1.
  - All other outputs and the shadow registers go to 0.
  - Reset wins over every other input, including mid-run.
- Configuration is valid when CFG_WIDTH≠0 and CFG_DELAY+CFG_WIDTH≤WINDOW. The check uses 17-bit arithmetic.
- IDLE, on START:
  - Invalid config: ERR←1; stay in IDLE.
  - Valid config, NWIN=0: go to FINISH.
  - Valid config, NWIN>0: GEN_DELAY←CFG_DELAY; GEN_WIDTH←CFG_WIDTH; WIN_IDX←0; go to ARM.
- ARM: lasts 1 cycle; GEN_RESET=1; tick←0; go to RUN.
- RUN:
  - GEN_RESET=0, PULSE_GATE=1; tick counts 0..WINDOW-1.
  - WIN_START=1 when tick=0.
  - At tick=WINDOW-1, if WIN_IDX+1=NWIN: go to FINISH.
  - Otherwise at tick=WINDOW-1:
    - WIN_IDX increments.
    - next_delay = GEN_DELAY+CFG_STEP, computed in 17 bits.
    - If next_delay+GEN_WIDTH>WINDOW, GEN_DELAY←CFG_DELAY (wrap to scan start); else GEN_DELAY←next_delay.
    - Go to GAP if CFG_GAP>0, else to ARM.
- GAP: GEN_RESET=1, PULSE_GATE=0; counts CFG_GAP cycles, then goes to ARM.
- FINISH: lasts 1 cycle; DONE=1, BUSY=0, GEN_RESET=1; go to IDLE. WIN_IDX holds its last value.
- ABORT in ARM, RUN or GAP: next state is FINISH. ABORT takes priority over every in-state transition.
- START while not in IDLE is ignored. CFG_WE outside IDLE is ignored.
- CFG_WE and START together in IDLE: the config is latched first, and START validates the newly latched values.

## Timing
- START sampled at edge t:
  - ARM during cycle t+1.
  - First RUN cycle t+2, with WIN_START=1 and PULSE_GATE=1.
- Each window: WINDOW cycles of RUN, followed by CFG_GAP cycles of GAP (if CFG_GAP>0) and 1 cycle of ARM before the next window.
- DONE cycle = t+2+N·WINDOW+(N-1)·(CFG_GAP+1), where N=CFG_NWIN.
- Empty run (NWIN=0): DONE at t+1.
- Rejected START: ERR high from t+1; no DONE.
- GEN_DELAY and WIN_IDX update on the last RUN edge of a window. They are therefore stable before the following ARM.
- ABORT sampled at edge a: DONE and GEN_RESET=1 in cycle a+1; IDLE from a+2.

## Test plan
- Reset: hold RESET_N=0 for 3 cycles with START=1 -> GEN_RESET=1, BUSY=0, DONE=0, ERR=0, GEN_DELAY=0.
- Single window (DELAY=32, WIDTH=86, NWIN=1, GAP=0), START at t:
  - WIN_START only at t+2.
  - PULSE_GATE high t+2..t+513.
  - DONE at t+514.
- Delay scan with wrap (DELAY=400, WIDTH=86, STEP=20, NWIN=3, GAP=4):
  - GEN_DELAY sequence is 400, 420, then 400 (wrap, since 440+86>512).
  - WIN_IDX sequence is 0, 1, 2.
  - DONE at t+2+1536+10.
- Rejected and empty runs:
  - WIDTH=0 then START -> ERR=1 sticky, state stays IDLE.
  - CFG_WE -> ERR cleared.
  - NWIN=0 then START -> DONE at t+1 with BUSY never high.
- Abort at RUN tick 100 of window 1 (NWIN=4) -> DONE next cycle, GEN_RESET=1, WIN_IDX=1; a START 2 cycles later is accepted.
- Guard and mid-run reset:
  - START and CFG_WE while BUSY -> ignored, and shadow registers are unchanged.
  - RESET_N low mid-GAP -> IDLE next cycle with no DONE.

Source files
------------

// File: rtl/neutron_burst_scheduler.sv
// Burst sequencer for the neutron pulse generator: runs NWIN windows of WINDOW ticks,
// stepping the pulse delay after each window and wrapping to the scan start when it no longer fits.
module neutron_burst_scheduler #(
    parameter int WINDOW = 512
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cfg_we,
    input  logic [15:0] cfg_delay,
    input  logic [15:0] cfg_width,
    input  logic [15:0] cfg_step,
    input  logic [7:0]  cfg_nwin,
    input  logic [15:0] cfg_gap,
    input  logic        start,
    input  logic        abort,
    output logic        gen_reset,
    output logic [15:0] gen_delay,
    output logic [15:0] gen_width,
    output logic        win_start,
    output logic        pulse_gate,
    output logic [7:0]  win_idx,
    output logic        busy,
    output logic        done,
    output logic        err
);
    localparam logic [16:0] WINDOW_17 = 17'(WINDOW);
    localparam logic [17:0] WINDOW_18 = 18'(WINDOW);
    localparam logic [15:0] TICK_LAST = 16'(WINDOW - 1);

    typedef enum logic [2:0] {IDLE, ARM, RUN, GAP, FINISH} state_t;
    state_t state_reg, state_next;

    logic [15:0] sh_delay_reg, sh_delay_next;
    logic [15:0] sh_width_reg, sh_width_next;
    logic [15:0] sh_step_reg, sh_step_next;
    logic [7:0]  sh_nwin_reg, sh_nwin_next;
    logic [15:0] sh_gap_reg, sh_gap_next;
    logic [15:0] gen_delay_reg, gen_delay_next;
    logic [15:0] gen_width_reg, gen_width_next;
    logic [7:0]  win_idx_reg, win_idx_next;
    logic [15:0] tick_reg, tick_next;
    logic [15:0] gap_cnt_reg, gap_cnt_next;
    logic        err_reg, err_next;
    logic        gen_reset_reg, win_start_reg, pulse_gate_reg, busy_reg, done_reg;

    // START in IDLE validates whatever is being latched in the same cycle.
    logic [15:0] eff_delay, eff_width;
    logic [7:0]  eff_nwin;
    logic        eff_valid;
    assign eff_delay = cfg_we ? cfg_delay : sh_delay_reg;
    assign eff_width = cfg_we ? cfg_width : sh_width_reg;
    assign eff_nwin  = cfg_we ? cfg_nwin  : sh_nwin_reg;
    assign eff_valid = (eff_width != 16'd0) &&
                       (({1'b0, eff_delay} + {1'b0, eff_width}) <= WINDOW_17);

    logic [16:0] next_delay;
    logic [17:0] scan_sum;
    logic        last_tick, last_window, in_run_states;
    assign next_delay    = {1'b0, gen_delay_reg} + {1'b0, sh_step_reg};
    assign scan_sum      = {1'b0, next_delay} + {2'b00, gen_width_reg};
    assign last_tick     = (tick_reg == TICK_LAST);
    assign last_window   = (({1'b0, win_idx_reg} + 9'd1) == {1'b0, sh_nwin_reg});
    assign in_run_states = (state_reg == ARM) || (state_reg == RUN) || (state_reg == GAP);

    always_comb begin
        state_next     = state_reg;
        sh_delay_next  = sh_delay_reg;
        sh_width_next  = sh_width_reg;
        sh_step_next   = sh_step_reg;
        sh_nwin_next   = sh_nwin_reg;
        sh_gap_next    = sh_gap_reg;
        gen_delay_next = gen_delay_reg;
        gen_width_next = gen_width_reg;
        win_idx_next   = win_idx_reg;
        tick_next      = tick_reg;
        gap_cnt_next   = gap_cnt_reg;
        err_next       = err_reg;
        if (abort && in_run_states) begin
            state_next = FINISH;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cfg_we) begin
                        sh_delay_next = cfg_delay;
                        sh_width_next = cfg_width;
                        sh_step_next  = cfg_step;
                        sh_nwin_next  = cfg_nwin;
                        sh_gap_next   = cfg_gap;
                        err_next      = 1'b0;
                    end
                    if (start) begin
                        if (!eff_valid) begin
                            err_next = 1'b1;
                        end else if (eff_nwin == 8'd0) begin
                            state_next = FINISH;
                        end else begin
                            gen_delay_next = eff_delay;
                            gen_width_next = eff_width;
                            win_idx_next   = 8'd0;
                            state_next     = ARM;
                        end
                    end
                end
                ARM: begin
                    tick_next  = 16'd0;
                    state_next = RUN;
                end
                RUN: begin
                    tick_next = tick_reg + 16'd1;
                    if (last_tick) begin
                        if (last_window) begin
                            state_next = FINISH;
                        end else begin
                            win_idx_next   = win_idx_reg + 8'd1;
                            gen_delay_next = (scan_sum > WINDOW_18) ? sh_delay_reg : next_delay[15:0];
                            if (sh_gap_reg != 16'd0) begin
                                gap_cnt_next = 16'd0;
                                state_next   = GAP;
                            end else begin
                                state_next = ARM;
                            end
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt_reg == sh_gap_reg - 16'd1) begin
                        state_next = ARM;
                    end else begin
                        gap_cnt_next = gap_cnt_reg + 16'd1;
                    end
                end
                FINISH: state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            sh_delay_reg   <= 16'd0;
            sh_width_reg   <= 16'd0;
            sh_step_reg    <= 16'd0;
            sh_nwin_reg    <= 8'd0;
            sh_gap_reg     <= 16'd0;
            gen_delay_reg  <= 16'd0;
            gen_width_reg  <= 16'd0;
            win_idx_reg    <= 8'd0;
            tick_reg       <= 16'd0;
            gap_cnt_reg    <= 16'd0;
            err_reg        <= 1'b0;
            gen_reset_reg  <= 1'b1;
            win_start_reg  <= 1'b0;
            pulse_gate_reg <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            sh_delay_reg   <= sh_delay_next;
            sh_width_reg   <= sh_width_next;
            sh_step_reg    <= sh_step_next;
            sh_nwin_reg    <= sh_nwin_next;
            sh_gap_reg     <= sh_gap_next;
            gen_delay_reg  <= gen_delay_next;
            gen_width_reg  <= gen_width_next;
            win_idx_reg    <= win_idx_next;
            tick_reg       <= tick_next;
            gap_cnt_reg    <= gap_cnt_next;
            err_reg        <= err_next;
            // Status outputs are decoded from the next state so they line up with state_reg.
            gen_reset_reg  <= (state_next != RUN);
            win_start_reg  <= (state_next == RUN) && (state_reg == ARM);
            pulse_gate_reg <= (state_next == RUN);
            busy_reg       <= (state_next == ARM) || (state_next == RUN) || (state_next == GAP);
            done_reg       <= (state_next == FINISH);
        end
    end

    assign gen_reset  = gen_reset_reg;
    assign gen_delay  = gen_delay_reg;
    assign gen_width  = gen_width_reg;
    assign win_start  = win_start_reg;
    assign pulse_gate = pulse_gate_reg;
    assign win_idx    = win_idx_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign err        = err_reg;
endmodule
